// File: rtl/prefetch_unit_if.sv
// Fetch-side and program-bus signals of the prefetch unit.
// master is the prefetch unit; slave is the decoder plus memory.
interface prefetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LVL_W  = 3
);
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              fetch_req;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic [ADDR_W-1:0] fetch_pc;
  logic [LVL_W-1:0]  level;
  logic              bus_busy;
  logic [ADDR_W-1:0] addr_bus;
  logic [DATA_W-1:0] data_bus;
  logic              read_en;
  logic              psen;

  modport master (
    input  flush, new_pc, fetch_req, bus_busy, data_bus,
    output fetch_valid, fetch_data, fetch_pc, level,
    output addr_bus, read_en, psen
  );

  modport slave (
    output flush, new_pc, fetch_req, bus_busy, data_bus,
    input  fetch_valid, fetch_data, fetch_pc, level,
    input  addr_bus, read_en, psen
  );
endinterface

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue with wait-state program-bus reads,
// bus yield on data access, and flush/redirect.
module prefetch_unit #(
  parameter int              ADDR_W      = 16,
  parameter int              DATA_W      = 8,
  parameter int              DEPTH       = 4,
  parameter int              WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             reset,
  prefetch_unit_if.master  pf
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              issue, capture, pop;

  assign pop = pf.fetch_req && (level != '0) && !pf.flush;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    issue   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (!pf.flush && !pf.bus_busy && level < FULL) begin
          state_d = READ;
          cnt_d   = 4'(WAIT_STATES);
          issue   = 1'b1;
        end
      end
      READ: begin
        // bus_busy is deliberately ignored once a read is on the bus
        if (pf.flush) begin
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 4'd1;
        end else begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      fetch_addr <= RESET_PC;
      head_pc    <= RESET_PC;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pf.flush) begin
      fetch_addr <= pf.new_pc;
      head_pc    <= pf.new_pc;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
    end else begin
      if (issue) addr_q <= fetch_addr;
      if (capture) begin
        mem[wr_ptr] <= pf.data_bus;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        fetch_addr  <= fetch_addr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        head_pc <= head_pc + ADDR_W'(1);
      end
      unique case (1'b1)
        capture && !pop: level <= level + LVL_W'(1);
        pop && !capture: level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // read strobe comes straight from state so reset drops it at once
  assign pf.read_en     = (state == READ);
  assign pf.psen        = (state == READ);
  assign pf.addr_bus    = addr_q;
  assign pf.fetch_valid = (level != '0);
  assign pf.fetch_data  = mem[rd_ptr];
  assign pf.fetch_pc    = head_pc;
  assign pf.level       = level;
endmodule

// File: doc/prefetch_unit.md
# prefetch_unit

Parametrised instruction prefetch unit that sits between the CPU decode stage and the external program-memory bus. It fetches code bytes ahead of execution into a DEPTH-entry queue, with configurable bus wait states. It yields the bus to data accesses via `bus_busy`, and supports flush/redirect on jumps, calls, returns and interrupts. It generalises the single-byte, zero-wait code fetch to an arbitrary width, depth and wait-state count.

## Interface
- ADDR_W, 16, program address width
- DATA_W, 8, code byte width
- DEPTH, 4, queue entries; power of two, ≥2
- WAIT_STATES, 1, extra bus cycles `read_en` is held before data is sampled (0..15)
- RESET_PC, 0, fetch address after reset

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  redirect request, one-cycle pulse
- new_pc  in  ADDR_W  redirect target, valid with `flush`
- fetch_req  in  1  consumer pops head entry this edge
- fetch_valid  out  1  queue non-empty
- fetch_data  out  DATA_W  head code byte
- fetch_pc  out  ADDR_W  address of head byte
- level  out  $clog2(DEPTH)+1  current entry count
- bus_busy  in  1  data access owns the bus; no new fetch may start
- addr_bus  out  ADDR_W  program memory address
- data_bus  in  DATA_W  program memory read data
- read_en  out  1  bus read strobe
- psen  out  1  program store enable; identical to `read_en`

## Operation
- FSM has two states, IDLE and READ. `fetch_addr` is the next byte to fetch. `head_pc` is the address of the queue head.
- IDLE → READ at an edge when `!flush && !bus_busy && level < DEPTH`. At that edge:
  - `addr_bus` ← `fetch_addr`
  - `read_en`/`psen` ← 1
  - wait counter ← WAIT_STATES
- READ, counter ≠ 0: the counter decrements each edge. `addr_bus` and `read_en` are held. `bus_busy` is ignored once READ is entered.
- READ, counter = 0: at the edge, `data_bus` is written to the tail. At the same edge:
  - `fetch_addr` increments
  - `read_en`/`psen` ← 0
  - state → IDLE
- Only one read is ever outstanding. The capture therefore never overflows the queue.
- Pop: at an edge with `fetch_req && fetch_valid`, the head advances and `head_pc` increments. `fetch_req` with the queue empty is ignored.
- Simultaneous capture and pop: `level` is unchanged and both pointers advance.
- Flush (highest priority) takes effect at the edge where `flush`=1:
  - queue is emptied (`level` ← 0)
  - `fetch_addr` ← `new_pc` and `head_pc` ← `new_pc`
  - any READ is aborted: `read_en` ← 0, data discarded, state → IDLE
  - a pop or capture at the same edge is discarded
- Address arithmetic is modulo 2^ADDR_W: the address after 2^ADDR_W−1 is 0. Queue pointers wrap modulo DEPTH.
- `fetch_data` is the head storage entry. Storage is cleared on reset, so `fetch_data`=0 after reset.

## Timing
- Reset values:
  - `read_en`=0, `psen`=0
  - `addr_bus`=0, `fetch_valid`=0, `fetch_data`=0
  - `fetch_pc`=RESET_PC, `level`=0
  - state IDLE, `fetch_addr`=RESET_PC
- Reset asserted mid-READ drops `read_en` immediately, asynchronously.
- `read_en` is high for exactly WAIT_STATES+1 cycles per fetch, unless a flush aborts it.
- Back-to-back fetches have one IDLE cycle between reads. Peak throughput is one byte per WAIT_STATES+2 cycles.
- After the first post-reset edge, fetch latency is:
  - `read_en` high after edge E1
  - data captured at edge E1+WAIT_STATES+1
  - `fetch_valid` high after that edge
- Flush to first new `read_en`: the flush edge leaves IDLE, and the earliest issue is at the next edge.
- `fetch_valid`, `fetch_data` and `fetch_pc` are registered or storage-derived. There is no combinational path from `data_bus` or `fetch_req`.
- When `level`=DEPTH, no read is issued. Issue resumes the edge after a pop makes `level`<DEPTH.

## Test plan
- WAIT_STATES=1, memory returns byte = address[7:0], no pops.
  - `read_en` high 2 cycles per fetch, 3-cycle issue period.
  - Queue fills with 0x00..0x03 at PCs 0..3.
  - `level`=4, then no further `read_en`.
- Full queue, then pop every cycle.
  - `fetch_pc` runs 0,1,2,…
  - `fetch_data` matches the PC.
  - `level` never exceeds 4 or underflows.
  - Capture plus pop in the same edge leaves `level` unchanged.
- Flush with `new_pc`=0x1234 during the second cycle of a READ.
  - `read_en` low the next cycle.
  - The in-flight byte is not stored.
  - `level`=0.
  - The next read has `addr_bus`=0x1234, and `fetch_pc`=0x1234 when valid.
- `bus_busy` held high for 10 cycles while IDLE and not full: no `read_en` during that window.
- `bus_busy` raised mid-READ: the READ completes normally.
- Flush to `new_pc`=0xFFFF: fetches are issued at 0xFFFF, then 0x0000, then 0x0001, and `fetch_pc` wraps the same way.
- Async `reset` pulse mid-READ with WAIT_STATES=3.
  - `read_en` drops without waiting for a clock edge.
  - All outputs return to reset values.
  - Fetch restarts at RESET_PC after release.
